alu_regfile: RTL and testbench
==============================

ALU_REGFILE -- requirements
Module: alu_regfile

Interface
REQ-001 No parameters; the block SHALL be fixed at 16 registers x 32 bits and a 6-bit opcode.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 i_clk  in  1  rising-edge clock.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_clk_en  in  1  global clock enable; register-file state SHALL change only when high (except reset).
REQ-006 i_cs_b  in  1  register-file write select, active-low.
REQ-007 i_wen  in  4  byte-lane write enables; bit k covers data bits 8k+7:8k.
REQ-008 i_waddr  in  4  write register index.
REQ-009 i_din  in  32  write data.
REQ-010 i_raddr_0, i_raddr_1  in  4 each  read register indices.
REQ-011 o_dout_0, o_dout_1  out  32 each  read data.
REQ-012 i_din_a, i_din_b  in  32 each  ALU operands A (source) and B (effective address/immediate).
REQ-013 i_cin, i_vin  in  1 each  current carry and overflow flags.
REQ-014 i_opcode  in  6  ALU operation.
REQ-015 o_alu_dout  out  32  ALU result; o_cout, o_vout  out  1 each  new C/V; o_mcp  out  1  multicycle request.

Function
REQ-016 Write: at the rising edge with i_clk_en=1 and i_cs_b=0, each lane with i_wen[k]=1 SHALL load i_din[8k+7:8k] into register i_waddr; other lanes hold.
REQ-017 Reads SHALL be combinational (zero latency); a read of the register being written SHALL return the pre-edge value until the edge.
REQ-018 All 16 registers SHALL be ordinary storage; index 0 is not hardwired.
REQ-019 The ALU SHALL be purely combinational; unless stated, o_cout=i_cin and o_vout=i_vin.
REQ-020 ADD 100000: A+B; ADC 100010: A+B+cin; cout = bit-32 carry; vout = signed overflow.
REQ-021 SUB 100001: A-B; SBC 100011: A-B-!cin; cout = 1 when no borrow (A>=B unsigned for SUB); vout = signed overflow.
REQ-022 AND 100100, OR 100101, XOR 100110, BIC 100111 (A & ~B): bitwise.
REQ-023 Shifts use amount n=B[5:0]: ASR 001000, LSL 001001, LSR 001010, ROL 001011, ROR 001100.
REQ-024 For LSL/LSR, n>=32 SHALL give 0; for ASR, n>=32 SHALL give 32 copies of A[31]; rotates SHALL use n mod 32.
REQ-025 For shifts, cout = last bit shifted out; for n=0, cout=cin; for rotates, cout=cin.
REQ-026 MUL 001101: result = low 32 bits of A*B (unsigned); o_mcp SHALL be 1 for this opcode only.
REQ-027 NOT 001110: result = ~A.
REQ-028 LD_W 000000, LD_H 000001, LD_B 000010, STO_W 000011, STO_H 000100, STO_B 000101, BRA_CC 000110, CALL_CC 000111, LJMP 010000, LCALL 010100, MOV 011000: result = B.
REQ-029 MOVT 011100: result = {B[15:0], A[15:0]}.
REQ-030 Any other opcode: result = 0.
REQ-031 Arithmetic SHALL wrap modulo 2^32.

Reset
REQ-032 With i_rst=1 at a rising edge, all 16 registers SHALL clear to 0, regardless of i_clk_en, i_cs_b and i_wen.
REQ-033 Reset SHALL take priority over a simultaneous write.
REQ-034 ALU outputs SHALL not depend on reset.

Verification
REQ-035 Reset, then read all 16 indices -> all 0; write 0x12345678 to r5 with i_wen=1111, cs_b=0, clk_en=1 -> o_dout_0=0x12345678 after the edge, not before.
REQ-036 Lanes: r5=0x12345678, then write i_din=0xAABBCCDD with i_wen=0101 -> r5=0x12BB56DD; a write with cs_b=1 or clk_en=0 -> r5 unchanged.
REQ-037 ADD 0x7FFFFFFF+1 -> 0x80000000, cout=0, vout=1; ADD 0xFFFFFFFF+1 -> 0, cout=1, vout=0.
REQ-038 SUB 5-7 -> 0xFFFFFFFE, cout=0; SUB 7-5 -> 2, cout=1; SBC 7-5 with cin=0 -> 1.
REQ-039 LSL 0x80000001 by 1 -> 0x00000002, cout=1; ASR 0x80000000 by 40 -> 0xFFFFFFFF; ROR 0x1 by 33 -> 0x80000000.
REQ-040 MUL 0x10000 x 0x10001 -> 0x00010000 with o_mcp=1; MOVT A=0x1111ABCD, B=0x5678 -> 0x5678ABCD, o_mcp=0.

Source files
------------

// File: rtl/alu_regfile.sv
// alu_regfile: 16 x 32-bit register file with byte-lane writes and two
// combinational read ports, plus an independent combinational ALU
// (add/sub with carry and overflow, logic, shifts/rotates, multiply, moves).
module alu_regfile (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_en,
    input  logic        i_cs_b,
    input  logic [3:0]  i_wen,
    input  logic [3:0]  i_waddr,
    input  logic [31:0] i_din,
    input  logic [3:0]  i_raddr_0,
    input  logic [3:0]  i_raddr_1,
    output logic [31:0] o_dout_0,
    output logic [31:0] o_dout_1,
    input  logic [31:0] i_din_a,
    input  logic [31:0] i_din_b,
    input  logic        i_cin,
    input  logic        i_vin,
    input  logic [5:0]  i_opcode,
    output logic [31:0] o_alu_dout,
    output logic        o_cout,
    output logic        o_vout,
    output logic        o_mcp
);

    // ------------------------------------------------------------------
    // Opcode map
    // ------------------------------------------------------------------
    localparam logic [5:0] OP_LD_W    = 6'b000000;
    localparam logic [5:0] OP_LD_H    = 6'b000001;
    localparam logic [5:0] OP_LD_B    = 6'b000010;
    localparam logic [5:0] OP_STO_W   = 6'b000011;
    localparam logic [5:0] OP_STO_H   = 6'b000100;
    localparam logic [5:0] OP_STO_B   = 6'b000101;
    localparam logic [5:0] OP_BRA_CC  = 6'b000110;
    localparam logic [5:0] OP_CALL_CC = 6'b000111;
    localparam logic [5:0] OP_ASR     = 6'b001000;
    localparam logic [5:0] OP_LSL     = 6'b001001;
    localparam logic [5:0] OP_LSR     = 6'b001010;
    localparam logic [5:0] OP_ROL     = 6'b001011;
    localparam logic [5:0] OP_ROR     = 6'b001100;
    localparam logic [5:0] OP_MUL     = 6'b001101;
    localparam logic [5:0] OP_NOT     = 6'b001110;
    localparam logic [5:0] OP_LJMP    = 6'b010000;
    localparam logic [5:0] OP_LCALL   = 6'b010100;
    localparam logic [5:0] OP_MOV     = 6'b011000;
    localparam logic [5:0] OP_MOVT    = 6'b011100;
    localparam logic [5:0] OP_ADD     = 6'b100000;
    localparam logic [5:0] OP_SUB     = 6'b100001;
    localparam logic [5:0] OP_ADC     = 6'b100010;
    localparam logic [5:0] OP_SBC     = 6'b100011;
    localparam logic [5:0] OP_AND     = 6'b100100;
    localparam logic [5:0] OP_OR      = 6'b100101;
    localparam logic [5:0] OP_XOR     = 6'b100110;
    localparam logic [5:0] OP_BIC     = 6'b100111;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] r_regs [16];

    // Register-file update: reset clears every entry, otherwise enabled byte lanes load.
    // NOTE: every entry is cleared on reset because the architecture requires a
    // known all-zero file; this keeps the array in flops rather than a RAM macro.
    // NOTE: non-blocking assignments here mean a same-cycle read still sees the
    // pre-edge contents, which is exactly the read-during-write behaviour wanted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_clk_en && !i_cs_b) begin
            for (int k = 0; k < 4; k++) begin
                if (i_wen[k]) begin
                    r_regs[i_waddr][8*k +: 8] <= i_din[8*k +: 8];
                end
            end
        end
    end

    // Zero-latency read ports; index 0 is ordinary storage.
    assign o_dout_0 = r_regs[i_raddr_0];
    assign o_dout_1 = r_regs[i_raddr_1];

    // ------------------------------------------------------------------
    // ALU datapath (purely combinational, independent of reset)
    // ------------------------------------------------------------------
    logic               w_add_ci;
    logic               w_sub_ci;
    logic [32:0]        w_add_ext;
    logic [32:0]        w_sub_ext;
    logic               w_add_v;
    logic               w_sub_v;
    logic [5:0]         w_shamt;
    logic               w_shamt_zero;
    logic [32:0]        w_lsl_ext;
    logic [32:0]        w_lsr_ext;
    logic signed [32:0] w_asr_ext;
    logic [4:0]         w_rot_amt;
    logic [5:0]         w_rot_inv;
    logic [31:0]        w_rol;
    logic [31:0]        w_ror;
    logic [31:0]        w_mul;

    // Carry-in: ADD ignores cin, ADC adds it; SUB is A + ~B + 1, SBC is A + ~B + cin.
    assign w_add_ci  = (i_opcode == OP_ADC) ? i_cin : 1'b0;
    assign w_sub_ci  = (i_opcode == OP_SBC) ? i_cin : 1'b1;
    assign w_add_ext = {1'b0, i_din_a} + {1'b0, i_din_b} + {32'd0, w_add_ci};
    assign w_sub_ext = {1'b0, i_din_a} + {1'b0, ~i_din_b} + {32'd0, w_sub_ci};

    // Signed overflow: operands of matching (add) or differing (sub) sign
    // producing a result whose sign differs from A.
    assign w_add_v = (i_din_a[31] == i_din_b[31]) & (w_add_ext[31] ^ i_din_a[31]);
    assign w_sub_v = (i_din_a[31] ^ i_din_b[31]) & (w_sub_ext[31] ^ i_din_a[31]);

    // Shifts carry one extra bit to capture the last bit shifted out.
    // LSL: bit 32 holds A[32-n]; LSR/ASR: bit 0 holds A[n-1]. Amounts past
    // 32 naturally drain to zero (or to the sign for ASR).
    assign w_shamt      = i_din_b[5:0];
    assign w_shamt_zero = (w_shamt == 6'd0);
    assign w_lsl_ext    = {1'b0, i_din_a} << w_shamt;
    assign w_lsr_ext    = {i_din_a, 1'b0} >> w_shamt;
    assign w_asr_ext    = $signed({i_din_a, 1'b0}) >>> w_shamt;

    // Rotates use n mod 32; a zero amount leaves A unchanged because the
    // complementary 32-bit shift drains to zero.
    assign w_rot_amt = i_din_b[4:0];
    assign w_rot_inv = 6'd32 - {1'b0, w_rot_amt};
    assign w_rol     = (i_din_a << w_rot_amt) | (i_din_a >> w_rot_inv);
    assign w_ror     = (i_din_a >> w_rot_amt) | (i_din_a << w_rot_inv);

    // Low 32 bits of the unsigned product.
    assign w_mul = i_din_a * i_din_b;

    // Result and flag selection by opcode.
    // NOTE: all outputs take a default before the case so no opcode path can
    // leave one unassigned and infer a latch.
    always_comb begin
        o_alu_dout = '0;
        o_cout     = i_cin;
        o_vout     = i_vin;
        o_mcp      = 1'b0;
        case (i_opcode)
            OP_ADD, OP_ADC: begin
                o_alu_dout = w_add_ext[31:0];
                o_cout     = w_add_ext[32];
                o_vout     = w_add_v;
            end
            OP_SUB, OP_SBC: begin
                o_alu_dout = w_sub_ext[31:0];
                o_cout     = w_sub_ext[32];
                o_vout     = w_sub_v;
            end
            OP_AND: o_alu_dout = i_din_a & i_din_b;
            OP_OR:  o_alu_dout = i_din_a | i_din_b;
            OP_XOR: o_alu_dout = i_din_a ^ i_din_b;
            OP_BIC: o_alu_dout = i_din_a & ~i_din_b;
            OP_LSL: begin
                o_alu_dout = w_lsl_ext[31:0];
                if (!w_shamt_zero) begin
                    o_cout = w_lsl_ext[32];
                end
            end
            OP_LSR: begin
                o_alu_dout = w_lsr_ext[32:1];
                if (!w_shamt_zero) begin
                    o_cout = w_lsr_ext[0];
                end
            end
            OP_ASR: begin
                o_alu_dout = w_asr_ext[32:1];
                if (!w_shamt_zero) begin
                    o_cout = w_asr_ext[0];
                end
            end
            OP_ROL: o_alu_dout = w_rol;
            OP_ROR: o_alu_dout = w_ror;
            OP_MUL: begin
                o_alu_dout = w_mul;
                o_mcp      = 1'b1;
            end
            OP_NOT: o_alu_dout = ~i_din_a;
            OP_LD_W, OP_LD_H, OP_LD_B, OP_STO_W, OP_STO_H, OP_STO_B,
            OP_BRA_CC, OP_CALL_CC, OP_LJMP, OP_LCALL, OP_MOV: begin
                o_alu_dout = i_din_b;
            end
            OP_MOVT: o_alu_dout = {i_din_b[15:0], i_din_a[15:0]};
            default: o_alu_dout = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile: directed vectors with hand-computed expectations for the
// register file (reset, lane writes, enables, reset priority) and the ALU.
module tb_alu_regfile;

    logic        i_clk;
    logic        i_rst;
    logic        i_clk_en;
    logic        i_cs_b;
    logic [3:0]  i_wen;
    logic [3:0]  i_waddr;
    logic [31:0] i_din;
    logic [3:0]  i_raddr_0;
    logic [3:0]  i_raddr_1;
    logic [31:0] o_dout_0;
    logic [31:0] o_dout_1;
    logic [31:0] i_din_a;
    logic [31:0] i_din_b;
    logic        i_cin;
    logic        i_vin;
    logic [5:0]  i_opcode;
    logic [31:0] o_alu_dout;
    logic        o_cout;
    logic        o_vout;
    logic        o_mcp;

    int n_vec;
    int n_err;

    alu_regfile dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clk_en   (i_clk_en),
        .i_cs_b     (i_cs_b),
        .i_wen      (i_wen),
        .i_waddr    (i_waddr),
        .i_din      (i_din),
        .i_raddr_0  (i_raddr_0),
        .i_raddr_1  (i_raddr_1),
        .o_dout_0   (o_dout_0),
        .o_dout_1   (o_dout_1),
        .i_din_a    (i_din_a),
        .i_din_b    (i_din_b),
        .i_cin      (i_cin),
        .i_vin      (i_vin),
        .i_opcode   (i_opcode),
        .o_alu_dout (o_alu_dout),
        .o_cout     (o_cout),
        .o_vout     (o_vout),
        .o_mcp      (o_mcp)
    );

    // 100 MHz clock.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one ALU vector, let it settle, then compare result and flags.
    task automatic alu_vec(input string tag, input logic [5:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic vin,
                           input logic [31:0] res, input logic c, input logic v,
                           input logic mcp, input logic chk_c);
        i_opcode = op;
        i_din_a  = a;
        i_din_b  = b;
        i_cin    = cin;
        i_vin    = vin;
        #1;
        check({tag, ".res"}, o_alu_dout, res);
        if (chk_c) check({tag, ".c"}, {31'd0, o_cout}, {31'd0, c});
        check({tag, ".v"}, {31'd0, o_vout}, {31'd0, v});
        check({tag, ".mcp"}, {31'd0, o_mcp}, {31'd0, mcp});
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        i_rst     = 1'b1;
        i_clk_en  = 1'b0;
        i_cs_b    = 1'b1;
        i_wen     = 4'h0;
        i_waddr   = 4'd0;
        i_din     = 32'd0;
        i_raddr_0 = 4'd0;
        i_raddr_1 = 4'd0;
        i_din_a   = 32'd0;
        i_din_b   = 32'd0;
        i_cin     = 1'b0;
        i_vin     = 1'b0;
        i_opcode  = 6'b000000;

        // Reset, then every register reads zero.
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            i_raddr_0 = 4'(i);
            #1;
            check($sformatf("rst_r%0d", i), o_dout_0, 32'h0);
        end

        // Full-word write to r5: visible only after the edge.
        @(negedge i_clk);
        i_clk_en  = 1'b1;
        i_cs_b    = 1'b0;
        i_wen     = 4'hF;
        i_waddr   = 4'd5;
        i_din     = 32'h12345678;
        i_raddr_0 = 4'd5;
        #1;
        check("r5_pre_edge", o_dout_0, 32'h0);
        @(posedge i_clk);
        #1;
        check("r5_post_edge", o_dout_0, 32'h12345678);

        // Byte lanes 0 and 2 only.
        @(negedge i_clk);
        i_din = 32'hAABBCCDD;
        i_wen = 4'b0101;
        @(posedge i_clk);
        #1;
        check("r5_lanes", o_dout_0, 32'h12BB56DD);

        // Deselected write is ignored.
        @(negedge i_clk);
        i_cs_b = 1'b1;
        i_wen  = 4'hF;
        i_din  = 32'h0;
        @(posedge i_clk);
        #1;
        check("r5_cs_b_hi", o_dout_0, 32'h12BB56DD);

        // Clock-enable low blocks the write.
        @(negedge i_clk);
        i_cs_b   = 1'b0;
        i_clk_en = 1'b0;
        @(posedge i_clk);
        #1;
        check("r5_clk_en_lo", o_dout_0, 32'h12BB56DD);

        // r0 is ordinary storage; r5 untouched by the r0 write.
        @(negedge i_clk);
        i_clk_en  = 1'b1;
        i_waddr   = 4'd0;
        i_din     = 32'hDEADBEEF;
        i_raddr_1 = 4'd0;
        @(posedge i_clk);
        #1;
        check("r0_write", o_dout_1, 32'hDEADBEEF);
        check("r5_kept", o_dout_0, 32'h12BB56DD);

        // Reset beats a simultaneous write; ALU unaffected by reset.
        @(negedge i_clk);
        i_rst   = 1'b1;
        i_waddr = 4'd5;
        i_din   = 32'hFFFFFFFF;
        alu_vec("add_in_rst", 6'b100000, 32'h00000003, 32'h00000004, 1'b0, 1'b0,
                32'h00000007, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge i_clk);
        #1;
        check("r5_rst_prio", o_dout_0, 32'h0);
        check("r0_rst", o_dout_1, 32'h0);
        @(negedge i_clk);
        i_rst    = 1'b0;
        i_cs_b   = 1'b1;
        i_clk_en = 1'b0;

        // ALU vectors: tag, op, A, B, cin, vin, result, cout, vout, mcp, check cout.
        alu_vec("add_ovf",  6'b100000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
        alu_vec("add_wrap", 6'b100000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
        alu_vec("adc",      6'b100010, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b1);
        alu_vec("sub_neg",  6'b100001, 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        alu_vec("sub_pos",  6'b100001, 32'h00000007, 32'h00000005, 1'b0, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b1);
        alu_vec("sub_ovf",  6'b100001, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        alu_vec("sbc",      6'b100011, 32'h00000007, 32'h00000005, 1'b0, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1);
        alu_vec("and",      6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b1);
        alu_vec("or",       6'b100101, 32'hF0F0F0F0, 32'h0F000F00, 1'b1, 1'b1, 32'hFFF0FFF0, 1'b1, 1'b1, 1'b0, 1'b1);
        alu_vec("xor",      6'b100110, 32'hFFFF0000, 32'hFF00FF00, 1'b0, 1'b0, 32'h00FFFF00, 1'b0, 1'b0, 1'b0, 1'b1);
        alu_vec("bic",      6'b100111, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 1'b0, 32'hFFFF0000, 1'b0, 1'b0, 1'b0, 1'b1);
        alu_vec("lsl_1",    6'b001001, 32'h80000001, 32'h00000001, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b1, 1'b0, 1'b1);
        alu_vec("lsl_0",    6'b001001, 32'h00001234, 32'h00000000, 1'b1, 1'b0, 32'h00001234, 1'b1, 1'b0, 1'b0, 1'b1);
        alu_vec("lsl_32",   6'b001001, 32'h00000001, 32'h00000020, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
        alu_vec("lsr_31",   6'b001010, 32'h80000000, 32'h0000001F, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1);
        alu_vec("lsr_40",   6'b001010, 32'hFFFFFFFF, 32'h00000028, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);
        alu_vec("asr_40",   6'b001000, 32'h80000000, 32'h00000028, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        alu_vec("asr_4",    6'b001000, 32'h80000018, 32'h00000004, 1'b0, 1'b0, 32'hF8000001, 1'b1, 1'b0, 1'b0, 1'b1);
        alu_vec("ror_33",   6'b001100, 32'h00000001, 32'h00000021, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1);
        alu_vec("rol_1",    6'b001011, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1);
        alu_vec("mul",      6'b001101, 32'h00010000, 32'h00010001, 1'b1, 1'b1, 32'h00010000, 1'b1, 1'b1, 1'b1, 1'b1);
        alu_vec("movt",     6'b011100, 32'h1111ABCD, 32'h00005678, 1'b0, 1'b0, 32'h5678ABCD, 1'b0, 1'b0, 1'b0, 1'b1);
        alu_vec("not",      6'b001110, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        alu_vec("mov",      6'b011000, 32'h11111111, 32'h0000CAFE, 1'b0, 1'b0, 32'h0000CAFE, 1'b0, 1'b0, 1'b0, 1'b1);
        alu_vec("ld_b",     6'b000010, 32'h11111111, 32'h00000040, 1'b0, 1'b0, 32'h00000040, 1'b0, 1'b0, 1'b0, 1'b1);
        alu_vec("lcall",    6'b010100, 32'h11111111, 32'h00ABCDEF, 1'b1, 1'b0, 32'h00ABCDEF, 1'b1, 1'b0, 1'b0, 1'b1);
        alu_vec("illegal",  6'b111111, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
